// File: rtl/mem_read_responder_pkg.sv
// Shared definitions for the memory read responder: access-width encodings,
// FSM state type and the width-to-byte-count helper.
package mem_pkg;

    localparam logic [2:0] MA_BYTE = 3'b000;
    localparam logic [2:0] MA_HALF = 3'b001;
    localparam logic [2:0] MA_TRI  = 3'b010;
    localparam logic [2:0] MA_WORD = 3'b011;

    // Widest access in bytes; the byte index fits in 3 bits.
    localparam int MAX_BYTES = 6;
    localparam int IDX_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } mem_rsp_state_t;

    // Number of bytes moved for a given CTRL code; reserved codes give 0.
    function automatic logic [IDX_W-1:0] ctrl_to_nbytes(input logic [2:0] ctrl);
        logic [IDX_W-1:0] n;
        case (ctrl)
            MA_BYTE: n = 3'd1;
            MA_HALF: n = 3'd2;
            MA_TRI:  n = 3'd3;
            MA_WORD: n = 3'd6;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_read_responder_if.sv
// CPU-side handshake plus byte-memory port of the read responder.
// slave = responder view, master = CPU/memory environment view.
interface mem_read_responder_if #(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 16
);
    logic              ENABLE;
    logic [2:0]        CTRL;
    logic [DATA_W-1:0] ADDRESS;
    logic [DATA_W-1:0] READ;
    logic              HANDSHAKE;
    logic              ERR;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic              MEM_RE;
    logic [7:0]        MEM_RDATA;

    modport slave (
        input  ENABLE, CTRL, ADDRESS, MEM_RDATA,
        output READ, HANDSHAKE, ERR, MEM_ADDR, MEM_RE
    );

    modport master (
        output ENABLE, CTRL, ADDRESS, MEM_RDATA,
        input  READ, HANDSHAKE, ERR, MEM_ADDR, MEM_RE
    );
endinterface

// File: rtl/mem_read_responder_lat_pipe.sv
// Valid + byte-index shift register matching the fixed memory read latency,
// so each returning byte arrives tagged with its position in the result.
module lat_pipe #(
    parameter int DEPTH = 1,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [IDX_W-1:0] i_idx,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_idx [DEPTH];

    // Shift the issue tag along one stage per cycle; reset drops everything in flight.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) r_idx[i] <= '0;
        end else begin
            r_valid[0] <= i_valid;
            r_idx[0]   <= i_idx;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_idx[i]   <= r_idx[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_idx   = r_idx[DEPTH-1];

endmodule

// File: rtl/mem_read_responder.sv
// Responder end of the CPU memory-read handshake. Issues one byte read per
// cycle to a byte-wide synchronous memory and assembles the little-endian
// result, then pulses HANDSHAKE for one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for ENABLE; request latched on acceptance
// S_ISSUE | one MEM_RE per cycle for bytes 0..N-1
// S_DRAIN | issue finished, waiting for the last byte to return
// S_DONE  | one-cycle HANDSHAKE, READ/ERR presented
module mem_read_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = 48,
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    mem_read_responder_if.slave   bus
);

    mem_rsp_state_t    r_state;
    mem_rsp_state_t    w_next;
    logic [ADDR_W-1:0] r_base;
    logic [IDX_W-1:0]  r_nbytes;
    logic [IDX_W-1:0]  r_issue_k;
    logic              r_err_pend;
    logic              r_err_hold;
    logic [DATA_W-1:0] r_asm;
    logic [DATA_W-1:0] r_read_hold;
    logic [DATA_W-1:0] w_read;
    logic              w_issue;
    logic              w_accept;
    logic              w_pipe_valid;
    logic [IDX_W-1:0]  w_pipe_idx;
    logic              w_unused_addr;

    // Upper address bits are deliberately dropped; the memory is only 2^ADDR_W bytes.
    assign w_unused_addr = ^bus.ADDRESS[DATA_W-1:ADDR_W];

    assign w_accept = (r_state == S_IDLE) && bus.ENABLE;

    lat_pipe #(
        .DEPTH (MEM_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .i_clk   (CLK),
        .i_rst   (RESET),
        .i_valid (w_issue),
        .i_idx   (r_issue_k),
        .o_valid (w_pipe_valid),
        .o_idx   (w_pipe_idx)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode; DONE always returns to IDLE so ENABLE is re-sampled
    // only after the released CPU clock edge has had a chance to advance CtrlM.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.ENABLE) w_next = bus.CTRL[2] ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                w_issue = 1'b1;
                if (r_issue_k == r_nbytes - 3'd1) w_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (w_pipe_valid && (w_pipe_idx == r_nbytes - 3'd1)) w_next = S_DONE;
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch, issue counter, byte assembly and held result.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_base      <= '0;
            r_nbytes    <= '0;
            r_issue_k   <= '0;
            r_err_pend  <= 1'b0;
            r_err_hold  <= 1'b0;
            r_asm       <= '0;
            r_read_hold <= '0;
        end else if (w_accept) begin
            r_base     <= bus.ADDRESS[ADDR_W-1:0];
            r_nbytes   <= ctrl_to_nbytes(bus.CTRL);
            r_issue_k  <= '0;
            r_err_pend <= bus.CTRL[2];
            r_err_hold <= 1'b0;
            r_asm      <= '0;
        end else begin
            if (w_issue) r_issue_k <= r_issue_k + 3'd1;
            for (int b = 0; b < MAX_BYTES; b++) begin
                if (w_pipe_valid && (w_pipe_idx == 3'(b)))
                    r_asm[8*b +: 8] <= bus.MEM_RDATA;
            end
            if (r_state == S_DONE) begin
                r_read_hold <= w_read;
                r_err_hold  <= r_err_pend;
            end
        end
    end

    // A reserved request never touches memory, but force zero regardless.
    assign w_read = r_err_pend ? '0 : r_asm;

    assign bus.HANDSHAKE = (r_state == S_DONE);
    assign bus.READ      = (r_state == S_DONE) ? w_read : r_read_hold;
    assign bus.ERR       = (r_state == S_DONE) ? r_err_pend : r_err_hold;
    assign bus.MEM_RE    = w_issue;
    assign bus.MEM_ADDR  = w_issue ? (r_base + ADDR_W'(r_issue_k)) : '0;

endmodule

// File: tb/tb_mem_read_responder.sv
// Directed bench: two responders (memory latency 1 and 3) share one byte
// memory image; each has its own latency-matched read model.
module tb_mem_read_responder;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_fail = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    mem_read_responder_if #(.DATA_W(48), .ADDR_W(16)) b1 ();
    mem_read_responder_if #(.DATA_W(48), .ADDR_W(16)) b3 ();

    mem_read_responder #(.DATA_W(48), .ADDR_W(16), .MEM_LAT(1)) dut1 (
        .CLK(clk), .RESET(rst), .bus(b1.slave));
    mem_read_responder #(.DATA_W(48), .ADDR_W(16), .MEM_LAT(3)) dut3 (
        .CLK(clk), .RESET(rst), .bus(b3.slave));

    logic [7:0] mem [0:65535];
    logic [7:0] rd1;
    logic [7:0] rd3 [3];

    // Unrequested cycles return 0xEE so a spurious capture shows in READ.
    always @(posedge clk) rd1 <= b1.MEM_RE ? mem[b1.MEM_ADDR] : 8'hEE;
    always @(posedge clk) begin
        rd3[0] <= b3.MEM_RE ? mem[b3.MEM_ADDR] : 8'hEE;
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign b1.MEM_RDATA = rd1;
    assign b3.MEM_RDATA = rd3[2];

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input bit s3, input logic en, input logic [2:0] ctrl, input logic [47:0] addr);
        if (s3) begin b3.ENABLE = en; b3.CTRL = ctrl; b3.ADDRESS = addr; end
        else    begin b1.ENABLE = en; b1.CTRL = ctrl; b1.ADDRESS = addr; end
    endtask

    function automatic logic g_hs(input bit s3);
        return s3 ? b3.HANDSHAKE : b1.HANDSHAKE;
    endfunction
    function automatic logic g_re(input bit s3);
        return s3 ? b3.MEM_RE : b1.MEM_RE;
    endfunction
    function automatic logic g_err(input bit s3);
        return s3 ? b3.ERR : b1.ERR;
    endfunction
    function automatic logic [15:0] g_addr(input bit s3);
        return s3 ? b3.MEM_ADDR : b1.MEM_ADDR;
    endfunction
    function automatic logic [47:0] g_read(input bit s3);
        return s3 ? b3.READ : b1.READ;
    endfunction

    // Present a request at the next edge (edge 0), drop ENABLE and scramble
    // CTRL/ADDRESS after acceptance, then follow the access cycle by cycle.
    task automatic run_req(input bit s3, input logic [2:0] ctrl, input logic [47:0] addr,
                           input int start_cyc, input int exp_cyc, input logic [47:0] exp_read,
                           input logic exp_err, input int exp_n, input string tag);
        int hs_cyc = -1;
        int re_cnt = 0;
        logic [15:0] exp_a = addr[15:0];
        set_in(s3, 1'b1, ctrl, addr);
        for (int cyc = start_cyc; cyc <= start_cyc + 40 && hs_cyc < 0; cyc++) begin
            @(negedge clk);
            if (cyc == start_cyc) set_in(s3, 1'b0, 3'b011, 48'hFFFF_FFFF_FF00);
            if (g_re(s3)) begin
                chk({tag, "_addr"}, 48'(g_addr(s3)), 48'(exp_a));
                exp_a++;
                re_cnt++;
            end
            if (g_hs(s3)) begin
                hs_cyc = cyc;
                chk({tag, "_read"}, g_read(s3), exp_read);
                chk({tag, "_err"}, 48'(g_err(s3)), 48'(exp_err));
            end
        end
        chk({tag, "_hs_cycle"}, 48'(hs_cyc), 48'(exp_cyc));
        chk({tag, "_re_count"}, 48'(re_cnt), 48'(exp_n));
        @(negedge clk);
        chk({tag, "_hs_single"}, 48'(g_hs(s3)), 48'h0);
        chk({tag, "_read_hold"}, g_read(s3), exp_read);
    endtask

    initial begin
        int hs_seen;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        for (int i = 0; i < 6; i++) mem[16'h0020 + i] = 8'(i + 1);
        mem[16'hFFFF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'h0030] = 8'h77;
        mem[16'h0031] = 8'h88;
        mem[16'h0032] = 8'h99;
        set_in(1'b0, 1'b0, 3'b000, 48'h0);
        set_in(1'b1, 1'b0, 3'b000, 48'h0);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_read", b1.READ, 48'h0);
        chk("rst_hs", 48'(b1.HANDSHAKE), 48'h0);
        chk("rst_re", 48'({b1.MEM_RE, b3.MEM_RE}), 48'h0);
        chk("rst_maddr", 48'(b1.MEM_ADDR), 48'h0);
        rst = 1'b0;
        @(negedge clk);

        // Byte, word, wrap with latency 3
        run_req(1'b0, MA_BYTE, 48'h0000_0000_0010, 1, 3, 48'h0000_0000_00A5, 1'b0, 1, "byte");
        @(negedge clk);
        run_req(1'b0, MA_WORD, 48'h0000_0000_0020, 1, 8, 48'h0605_0403_0201, 1'b0, 6, "word");
        @(negedge clk);
        run_req(1'b1, MA_HALF, 48'h1234_0000_FFFF, 1, 6, 48'h0000_0000_2211, 1'b0, 2, "wrap3");
        @(negedge clk);

        // Reset in mid-ISSUE of a word read
        set_in(1'b0, 1'b1, MA_WORD, 48'h20);
        @(negedge clk);
        set_in(1'b0, 1'b0, MA_BYTE, 48'h0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_mid_issue", 48'(b1.MEM_RE), 48'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_read", b1.READ, 48'h0);
        chk("abort_hs", 48'(b1.HANDSHAKE), 48'h0);
        chk("abort_err", 48'(b1.ERR), 48'h0);
        chk("abort_re", 48'(b1.MEM_RE), 48'h0);
        chk("abort_maddr", 48'(b1.MEM_ADDR), 48'h0);
        chk("abort_state", 48'(dut1.r_state), 48'(S_IDLE));
        rst = 1'b0;
        hs_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (b1.HANDSHAKE) hs_seen++;
        end
        chk("abort_no_hs", 48'(hs_seen), 48'h0);
        run_req(1'b0, MA_BYTE, 48'h10, 1, 3, 48'h0000_0000_00A5, 1'b0, 1, "after_rst");
        @(negedge clk);

        // Reserved CTRL, then ENABLE held for a 3-byte read
        set_in(1'b0, 1'b1, 3'b101, 48'h40);
        @(negedge clk);
        chk("rsv_hs", 48'(b1.HANDSHAKE), 48'h1);
        chk("rsv_err", 48'(b1.ERR), 48'h1);
        chk("rsv_read", b1.READ, 48'h0);
        chk("rsv_re", 48'(b1.MEM_RE), 48'h0);
        set_in(1'b0, 1'b1, MA_TRI, 48'h30);
        @(negedge clk);
        chk("b2b_idle_hs", 48'(b1.HANDSHAKE), 48'h0);
        chk("b2b_idle_re", 48'(b1.MEM_RE), 48'h0);
        chk("b2b_err_hold", 48'(b1.ERR), 48'h1);
        run_req(1'b0, MA_TRI, 48'h30, 3, 7, 48'h0000_0099_8877, 1'b0, 3, "b2b_tri");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
